// File: rtl/count_irq_pkg.sv
// Shared constants for the count compare / interrupt unit: register offsets,
// CTRL field positions, channel count and a byte-lane merge helper.
package count_irq_pkg;

  localparam int NCH = 3;

  // Word offsets, taken from wbs_adr_i[4:2]
  localparam logic [2:0] OFS_CTRL    = 3'd0;
  localparam logic [2:0] OFS_CMP0    = 3'd1;
  localparam logic [2:0] OFS_CMP1    = 3'd2;
  localparam logic [2:0] OFS_CMP2    = 3'd3;
  localparam logic [2:0] OFS_STATUS  = 3'd4;
  localparam logic [2:0] OFS_CAPTURE = 3'd5;

  // CTRL fields: channel enable at [2:0], irq enable at [6:4]
  localparam int CTRL_EN_LSB = 0;
  localparam int CTRL_IE_LSB = 4;

  // Replace the bytes of old_val whose lane is selected with new_val bytes
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/count_cmp_channel.sv
// One compare channel: holds the compare value, remembers whether count
// matched last cycle, and pulses hit on the first cycle of a match.
module count_cmp_channel
  import count_irq_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] count,
  input  logic            en,
  input  logic            we,
  input  logic [3:0]      sel,
  input  logic [31:0]     wdata,
  output logic            hit,
  output logic [BITS-1:0] cmp
);

  logic [BITS-1:0] cmp_d, cmp_q;
  logic            eq_d, eq_q;
  logic            eq;
  logic [31:0]     merged;

  // Match detect and byte-lane update of the compare value
  always_comb begin
    eq     = (count == cmp_q);
    eq_d   = eq;
    merged = merge_bytes(32'(cmp_q), wdata, sel);
    cmp_d  = we ? merged[BITS-1:0] : cmp_q;
  end

  // Only the first matching cycle fires, so a stalled count hits once
  assign hit = en & eq & ~eq_q;
  assign cmp = cmp_q;

  // Compare value and previous-match flop
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q <= '0;
      eq_q  <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      eq_q  <= eq_d;
    end
  end

endmodule

// File: rtl/count_irq_ctrl.sv
// Wishbone slave that compares the user-area counter against three
// programmable values and raises level interrupts from sticky hit flags.
module count_irq_ctrl
  import count_irq_pkg::*;
#(
  parameter int          BITS      = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [BITS-1:0] count,
  output logic [2:0]      irq
);

  // Handshake: an access is accepted when cyc & stb are high on a selected
  // address and no ack is pending; ack then pulses for exactly one cycle
  // with read data valid alongside it, and the write lands on the accepting
  // edge. Unselected addresses are never acked and wbs_dat_o keeps its value.
  logic            sel_hit, access, wr, rd;
  logic [2:0]      ofs;
  logic            ack_d, ack_q;
  logic [31:0]     dat_d, dat_q, rdata;
  logic [NCH-1:0]  en_d, en_q, ie_d, ie_q, status_d, status_q, clr;
  logic [BITS-1:0] cap_d, cap_q;
  logic [NCH-1:0]  hit, cmp_we;
  logic [BITS-1:0] cmp_rd [NCH];
  logic            unused_adr;

  assign sel_hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign access     = wbs_cyc_i & wbs_stb_i & ~ack_q & sel_hit;
  assign wr         = access & wbs_we_i;
  assign rd         = access & ~wbs_we_i;
  assign ofs        = wbs_adr_i[4:2];
  assign unused_adr = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign cmp_we[g] = wr && (ofs == OFS_CMP0 + 3'(g));
    count_cmp_channel #(.BITS(BITS)) u_ch (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .count (count),
      .en    (en_q[g]),
      .we    (cmp_we[g]),
      .sel   (wbs_sel_i),
      .wdata (wbs_dat_i),
      .hit   (hit[g]),
      .cmp   (cmp_rd[g])
    );
  end

  // CTRL writes, STATUS set/clear (a new hit beats a same-cycle clear), CAPTURE
  always_comb begin
    en_d = en_q;
    ie_d = ie_q;
    clr  = '0;
    if (wr && ofs == OFS_CTRL && wbs_sel_i[0]) begin
      en_d = wbs_dat_i[CTRL_EN_LSB +: NCH];
      ie_d = wbs_dat_i[CTRL_IE_LSB +: NCH];
    end
    if (wr && ofs == OFS_STATUS && wbs_sel_i[0]) begin
      clr = wbs_dat_i[NCH-1:0];
    end
    status_d = (status_q & ~clr) | hit;
    cap_d    = (|hit) ? count : cap_q;
  end

  // Read mux; the output register only reloads on an accepted read
  always_comb begin
    rdata = '0;
    case (ofs)
      OFS_CTRL: begin
        rdata[CTRL_EN_LSB +: NCH] = en_q;
        rdata[CTRL_IE_LSB +: NCH] = ie_q;
      end
      OFS_CMP0:    rdata = 32'(cmp_rd[0]);
      OFS_CMP1:    rdata = 32'(cmp_rd[1]);
      OFS_CMP2:    rdata = 32'(cmp_rd[2]);
      OFS_STATUS:  rdata[NCH-1:0] = status_q;
      OFS_CAPTURE: rdata = 32'(cap_q);
      default:     rdata = '0;
    endcase
    dat_d = rd ? rdata : dat_q;
    ack_d = access;
  end

  // Register state
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      en_q     <= '0;
      ie_q     <= '0;
      status_q <= '0;
      cap_q    <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      en_q     <= en_d;
      ie_q     <= ie_d;
      status_q <= status_d;
      cap_q    <= cap_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = status_q & ie_q;

endmodule

// File: doc/count_irq_ctrl.md
# count_irq_ctrl

Wishbone-slave compare/interrupt unit that sits directly downstream of the user-area counter: it consumes the counter's `count` bus and raises the user-area `irq[2:0]` lines when the count hits programmable compare values. The management SoC programs compare values, enables and masks, then reads and clears sticky status over Wishbone. One clock domain (`wb_clk_i`); the counter's `count` must be driven from the same clock.

## Interface
- `BITS`, 32: width of `count` and the compare registers (≤ 32).
- `BASE_ADDR`, 32'h3000_0100: the block responds when `wbs_adr_i[31:8] == BASE_ADDR[31:8]`.
- `NCH`, 3: number of compare channels. Fixed at 3; each channel drives one `irq` bit.

Ports:
- `wb_clk_i`  in  1  clock; all logic on rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic cycle/strobe/write.
- `wbs_sel_i`  in  4  byte lanes.
- `wbs_adr_i`  in  32  byte address; offset = `[4:2]`.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  acknowledge.
- `wbs_dat_o`  out  32  read data, registered.
- `count`  in  BITS  counter value.
- `irq`  out  3  level interrupts.

## Operation
- Register map (word offsets):
  - 0x00 CTRL: `[2:0]` channel enable; `[6:4]` irq enable.
  - 0x04/0x08/0x0C: CMP0..CMP2, BITS wide.
  - 0x10 STATUS: `[2:0]` sticky hit; write-1-to-clear. Reads return live flags.
  - 0x14 CAPTURE: `count` latched on the most recent hit of any channel. Read-only.
  - 0x18–0x1C: read 0, writes ignored, still acked.
- Writes honour `wbs_sel_i` per byte. Bits above BITS, and unused CTRL bits, read 0.
- Per channel i:
  - `eq_i = (count == CMP_i)`.
  - `eq_q_i` holds `eq_i` registered every cycle.
  - `hit_i = CTRL.en[i] & eq_i & ~eq_q_i`. This is a rising-edge detect, so a frozen count fires only once.
  - A hit sets `STATUS[i]` and loads CAPTURE with `count`.
- `irq[i] = STATUS[i] & CTRL.ie[i]`, driven from registers, no combinational path from inputs.
- Simultaneous events:
  - W1C and hit on the same bit in the same cycle: set wins.
  - Hits on several channels in the same cycle: all flags set; CAPTURE takes the single shared `count`.
- Writing CMP_i to the value `count` currently holds: `eq_q_i` was 0, so the hit fires one cycle after the write is acked.
- Count wrap-around (all-ones to 0) needs no special handling. Equality is exact, BITS-wide.

## Timing
- Reset values: CTRL, CMP0–2, STATUS, CAPTURE, `eq_q` = 0; `wbs_ack_o` = 0; `wbs_dat_o` = 0; `irq` = 0.
- Reset asserted mid-transaction: ack drops the next edge and all state clears. The master must restart.
- Wishbone handshake:
  - Selected `cyc&stb&~ack` sampled at edge N: `wbs_ack_o` = 1 and `wbs_dat_o` valid during cycle N+1.
  - The write takes effect at edge N.
  - Ack deasserts at N+1, giving single-cycle pulses. Back-to-back accesses therefore take 2 cycles each.
  - Unselected addresses get no ack; `wbs_dat_o` holds its last value.
- Hit latency: `count == CMP_i` first sampled at edge N sets STATUS and CAPTURE at edge N. `irq[i]` is high from cycle N+1.
- Clearing STATUS via W1C at edge N drops `irq[i]` in cycle N+1.

## Structure
- Package `count_irq_pkg` holds:
  - register offset localparams (`OFS_CTRL` … `OFS_CAPTURE`);
  - CTRL field positions;
  - `NCH`.
- Sub-module `count_cmp_channel` is instantiated NCH times. It holds CMP, `eq_q` and hit generation; its inputs are `count`, enable, write-enable and data, and its outputs are `hit` and `cmp` for readback.
- The top level holds:
  - Wishbone decode and ack;
  - CTRL, STATUS and CAPTURE;
  - the read mux and `irq`.

## Test plan
- **Reset:** hold `wb_rst_i` 2 cycles → all reads return 0, `irq=0`, `wbs_ack_o=0`.
- **Register access:**
  - Write CMP1=0x0000_00A5 with `sel=4'b0001` over prior 0x1234_5678 → readback 0x1234_56A5.
  - Ack is high exactly 1 cycle after stb.
- **Compare hit:**
  - Setup: CTRL=0x11, CMP0=10, count ramping by 1 each cycle.
  - STATUS=0x1 from the edge count==10; `irq[0]` high the next cycle; CAPTURE=10.
  - count held at 10 for 5 cycles → no re-hit after W1C.
- **W1C collision:** STATUS write 0x1 in the same cycle as a new channel-0 hit → STATUS stays 0x1.
- **Masking and multi-hit:**
  - CTRL=0x07 (ie=0), CMP0=CMP2=20 → STATUS=0x5, `irq=0`.
  - Then CTRL=0x57 → `irq=3'b101`.
- **Write-equal:** count frozen at 7, write CMP2=7 with en[2]=1 → STATUS[2] set one cycle after ack; wrap 0xFFFF_FFFF→0 with CMP=0 → hit.
